// File: rtl/spi_baud_gen.sv
// SPI master serial-clock generator: divides PCLK by (sppr+1)*2^(spr+1) and emits
// registered MISO-sample / MOSI-drive strobes. Optional macro: SPI_BAUD_WAIT_HOLD_EN.
module spi_baud_gen (
  input  logic        PCLK,
  input  logic        PRESET_n,
  input  logic [1:0]  spi_mode_i,
  input  logic        spiswai_i,
  input  logic [2:0]  sppr_i,
  input  logic [2:0]  spr_i,
  input  logic        cpol_i,
  input  logic        cpha_i,
  input  logic        ss_i,
  output logic        sclk_o,
  output logic        miso_receive_sclk_o,
  output logic        miso_receive_sclk0_o,
  output logic        mosi_send_sclk_o,
  output logic        mosi_send_sclk0_o,
  output logic [11:0] baudratedivisor_o
);

  logic [3:0]  pre_div;
  logic [3:0]  shamt;
  logic [11:0] half;
  logic [11:0] half_m1;
  logic [11:0] half_m2;

  assign pre_div           = {1'b0, sppr_i} + 4'd1;
  assign shamt             = {1'b0, spr_i} + 4'd1;
  assign baudratedivisor_o = {8'd0, pre_div} << shamt;
  assign half              = baudratedivisor_o >> 1;
  assign half_m1           = half - 12'd1;
  // With half==1 the drive strobe shares the toggle cycle (cnt==0).
  assign half_m2           = (half == 12'd1) ? 12'd0 : (half - 12'd2);

  logic run;
  assign run = ~ss_i & ((spi_mode_i == 2'b00) | ((spi_mode_i == 2'b01) & ~spiswai_i));

`ifdef SPI_BAUD_WAIT_HOLD_EN
  logic halt;
  assign halt = ~ss_i & (spi_mode_i == 2'b01) & spiswai_i;
`endif

  logic [11:0] cnt_q, cnt_d;
  logic        sclk_q, sclk_d;
  logic [3:0]  strb_q, strb_d;

  always_comb begin
    cnt_d  = '0;
    sclk_d = cpol_i;
    if (run) begin
      if (cnt_q == half_m1) begin
        cnt_d  = '0;
        sclk_d = ~sclk_q;
      end else begin
        cnt_d  = cnt_q + 12'd1;
        sclk_d = sclk_q;
      end
    end
`ifdef SPI_BAUD_WAIT_HOLD_EN
    else if (halt) begin
      cnt_d  = cnt_q;
      sclk_d = sclk_q;
    end
`endif
  end

  // Strobes are evaluated on the next-state counter so the registered pulse lands in
  // the very cycle whose cnt matches; a cycle following an inactive one carries none.
  logic leading, sample, rise, miso_hit, mosi_hit;

  always_comb begin
    leading  = (sclk_d == cpol_i);
    sample   = leading ^ cpha_i;
    rise     = ~sclk_d;
    miso_hit = run & (cnt_d == half_m1) &  sample;
    mosi_hit = run & (cnt_d == half_m2) & ~sample;
    strb_d   = {miso_hit & rise, miso_hit & ~rise, mosi_hit & rise, mosi_hit & ~rise};
  end

  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
      strb_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
      strb_q <= strb_d;
    end
  end

  assign sclk_o = sclk_q;
  assign {miso_receive_sclk_o, miso_receive_sclk0_o, mosi_send_sclk_o, mosi_send_sclk0_o} = strb_q;

endmodule

// File: tb/tb_spi_baud_gen.sv
// Scoreboard bench for spi_baud_gen: a time-based SCLK model predicts every cycle.
module tb_spi_baud_gen;

  logic        PCLK = 1'b0;
  logic        PRESET_n;
  logic [1:0]  spi_mode_i;
  logic        spiswai_i;
  logic [2:0]  sppr_i;
  logic [2:0]  spr_i;
  logic        cpol_i;
  logic        cpha_i;
  logic        ss_i;
  logic        sclk_o;
  logic        miso_receive_sclk_o;
  logic        miso_receive_sclk0_o;
  logic        mosi_send_sclk_o;
  logic        mosi_send_sclk0_o;
  logic [11:0] baudratedivisor_o;

  spi_baud_gen dut (
    .PCLK                 (PCLK),
    .PRESET_n             (PRESET_n),
    .spi_mode_i           (spi_mode_i),
    .spiswai_i            (spiswai_i),
    .sppr_i               (sppr_i),
    .spr_i                (spr_i),
    .cpol_i               (cpol_i),
    .cpha_i               (cpha_i),
    .ss_i                 (ss_i),
    .sclk_o               (sclk_o),
    .miso_receive_sclk_o  (miso_receive_sclk_o),
    .miso_receive_sclk0_o (miso_receive_sclk0_o),
    .mosi_send_sclk_o     (mosi_send_sclk_o),
    .mosi_send_sclk0_o    (mosi_send_sclk0_o),
    .baudratedivisor_o    (baudratedivisor_o)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        sclk;
    logic [3:0]  strb;   // {miso_rise, miso_fall, mosi_rise, mosi_fall}
    logic [11:0] div;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: active cycles elapsed since activation, and the current SCLK level.
  int   m_t = 0;
  logic m_sclk = 1'b0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Predict the outputs after the coming posedge from the inputs now applied.
  task automatic step();
    exp_t e;
    int   h, pos, sm2;
    logic s, smp, act, hold;
    h    = (int'(sppr_i) + 1) << spr_i;
    act  = !ss_i && (spi_mode_i == 2'b00 || (spi_mode_i == 2'b01 && !spiswai_i));
    hold = !ss_i && spi_mode_i == 2'b01 && spiswai_i;
    e.div  = 12'((int'(sppr_i) + 1) << (int'(spr_i) + 1));
    e.strb = 4'b0000;
    if (act) begin
      m_t++;
      s   = cpol_i ^ logic'((m_t / h) % 2);
      pos = m_t % h;
      sm2 = (h >= 2) ? h - 2 : 0;
      smp = (s == cpol_i) ^ cpha_i;
      if (smp && pos == h - 1)       e.strb = s ? 4'b0100 : 4'b1000;
      else if (!smp && pos == sm2)   e.strb = s ? 4'b0001 : 4'b0010;
      m_sclk = s;
    end
`ifdef SPI_BAUD_WAIT_HOLD_EN
    else if (hold) begin
      m_t = m_t;
    end
`endif
    else begin
      m_t    = 0;
      m_sclk = cpol_i;
    end
    if (hold && act) m_t = m_t;
    e.sclk = m_sclk;
    sbq.push_back(e);
    @(negedge PCLK);
  endtask

  always begin
    exp_t e;
    logic [3:0] got;
    @(posedge PCLK);
    #1;
    if (sbq.size() > 0) begin
      e   = sbq.pop_front();
      got = {miso_receive_sclk_o, miso_receive_sclk0_o, mosi_send_sclk_o, mosi_send_sclk0_o};
      chk("sclk", int'(sclk_o), int'(e.sclk));
      chk("strobes", int'(got), int'(e.strb));
      chk("divisor", int'(baudratedivisor_o), int'(e.div));
      chk("onehot", int'($countones(got) > 1), 0);
    end
  end

  task automatic setup(input logic [1:0] md, input logic sw, input logic [2:0] pp,
                       input logic [2:0] r, input logic pol, input logic pha);
    ss_i = 1'b1; spi_mode_i = md; spiswai_i = sw;
    sppr_i = pp; spr_i = r; cpol_i = pol; cpha_i = pha;
    step(); step();
  endtask

  task automatic burst(input logic [1:0] md, input logic sw, input logic [2:0] pp,
                       input logic [2:0] r, input logic pol, input logic pha, input int len);
    setup(md, sw, pp, r, pol, pha);
    ss_i = 1'b0;
    repeat (len) step();
  endtask

  initial begin
    PRESET_n = 1'b0; ss_i = 1'b1; spi_mode_i = 2'b00; spiswai_i = 1'b0;
    sppr_i = 3'd0; spr_i = 3'd0; cpol_i = 1'b0; cpha_i = 1'b0;
    repeat (2) @(negedge PCLK);
    chk("rst_sclk", int'(sclk_o), 0);
    chk("rst_strobes", int'({miso_receive_sclk_o, miso_receive_sclk0_o,
                             mosi_send_sclk_o, mosi_send_sclk0_o}), 0);
    PRESET_n = 1'b1;
    cpol_i = 1'b1;
    step(); step();

    // Wait mode, divisor 8, cpol=1 cpha=1, then every cpol/cpha pair.
    burst(2'b01, 1'b0, 3'd0, 3'd2, 1'b1, 1'b1, 40);
    for (int m = 0; m < 4; m++) burst(2'b00, 1'b0, 3'd0, 3'd2, m[1], m[0], 36);

    // Divisor extremes.
    setup(2'b00, 1'b0, 3'd7, 3'd7, 1'b0, 1'b0);
    burst(2'b00, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 12);
    burst(2'b00, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1, 12);

    // Abort via ss_i, then restart.
    burst(2'b00, 1'b0, 3'd2, 3'd1, 1'b0, 1'b1, 17);
    ss_i = 1'b1; step(); step();
    ss_i = 1'b0; repeat (30) step();

    // Wait-mode halt mid-transfer, then stop mode.
    burst(2'b01, 1'b0, 3'd1, 3'd1, 1'b1, 1'b0, 13);
    spiswai_i = 1'b1; repeat (5) step();
    spiswai_i = 1'b0; repeat (20) step();
    spi_mode_i = 2'b10; repeat (4) step();
    spi_mode_i = 2'b00; repeat (20) step();

    // Randomized bursts with occasional mid-transfer disturbances.
    for (int b = 0; b < 60; b++) begin
      logic [2:0] pp, r;
      int         len, ev;
      pp  = 3'($urandom_range(0, 7));
      r   = 3'($urandom_range(0, 2));
      len = $urandom_range(4, 3 * ((int'(pp) + 1) << (int'(r) + 1)) + 4);
      setup(2'($urandom_range(0, 1)), 1'b0, pp, r, 1'($urandom), 1'($urandom));
      ss_i = 1'b0;
      for (int c = 0; c < len; c++) begin
        ev = $urandom_range(0, 99);
        if (ev < 2)       ss_i = ~ss_i;
        else if (ev < 5)  spi_mode_i = 2'($urandom_range(0, 3));
        else if (ev < 9)  spiswai_i = ~spiswai_i;
        step();
      end
      ss_i = 1'b1; spi_mode_i = 2'b00; spiswai_i = 1'b0;
      step();
    end

    repeat (3) @(negedge PCLK);
    chk("sb_drain", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
